uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART_Tx serializer between up to NUM_REQ byte producers (register-file readback, ALU result, status reporter, ...). It accepts bytes over a valid/ready handshake and drives UART_Tx's DATA_Valid/P_DATA. It tracks UART_Tx's busy flag so a new byte is issued only after the previous frame is fully shifted out. Multi-byte messages can lock the grant until their last byte, so frames from different requesters never interleave.

---
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`timescale 1ns/1ps
// uart_tx_sched
// Round-robin scheduler that shares one UART_Tx serializer between NUM_REQ
// byte producers. A byte is accepted over a valid/ready handshake while the
// scheduler is idle. It is then presented to UART_Tx with a one-cycle
// DATA_Valid pulse. The next byte is held off until UART_Tx's busy flag has
// risen and fallen again. A byte with REQ_LAST=0 locks the grant to its
// owner, so the frames of a multi-byte message are never interleaved with
// frames from other requesters.
//
// Ports
//   CLK, RST       system clock, synchronous active-high reset
//   REQ_VALID      per-requester byte available
//   REQ_DATA       requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_LAST       byte ends its message (0 keeps the grant locked)
//   REQ_READY      one-hot accept, combinational, only asserted in IDLE
//   GRANT          one-hot current/last owner, 0 when idle and unlocked
//   TX_P_DATA      registered byte to UART_Tx P_DATA
//   TX_DATA_VALID  one-cycle pulse to UART_Tx DATA_Valid
//   TX_BUSY        UART_Tx busy flag
//   TIMEOUT_ERR    one-cycle pulse: busy never rose after an issue
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_LAST,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            GRANT,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_DATA_VALID,
  input  logic                          TX_BUSY,
  output logic                          TIMEOUT_ERR
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PW:0]   NREQ     = (PW+1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           rr_ptr;
  logic [PW-1:0]           owner;
  logic                    lock;
  logic [CW-1:0]           to_cnt;

  logic                    win_found;
  logic [PW-1:0]           win_idx;
  logic [PW-1:0]           cand;
  logic [DATA_WIDTH-1:0]   win_data;
  logic [NUM_REQ-1:0]      win_onehot;
  logic                    accept;
  logic                    timeout_hit;
  logic                    done;

  // (base + off) modulo NUM_REQ; both operands are already below NUM_REQ,
  // so a single conditional subtraction suffices.
  function automatic logic [PW-1:0] rr_add(input logic [PW-1:0] base,
                                           input logic [PW-1:0] off);
    logic [PW:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[PW-1:0];
  endfunction

  // Winner search. Walking the offsets downward and overwriting leaves the
  // smallest offset from rr_ptr as the winner without needing a break.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (lock) begin
      win_found = REQ_VALID[owner];
      win_idx   = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand = rr_add(rr_ptr, PW'(k));
        if (REQ_VALID[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_data      = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        // A busy flag seen here belongs to someone else and is ignored.
        if (win_found) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: begin
        if (TX_BUSY) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign REQ_READY     = accept ? win_onehot : '0;
  assign TX_DATA_VALID = (state == ISSUE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      lock        <= 1'b0;
      GRANT       <= '0;
      TX_P_DATA   <= '0;
      TIMEOUT_ERR <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      TIMEOUT_ERR <= timeout_hit;

      if (accept) begin
        TX_P_DATA <= win_data;
        owner     <= win_idx;
        GRANT     <= win_onehot;
        lock      <= ~REQ_LAST[win_idx];
      end

      if (state == ISSUE) begin
        to_cnt <= '0;
      end else if (state == WAIT_START && !TX_BUSY) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // A timed-out byte was already acknowledged, so it is dropped and the
      // whole message is abandoned: the lock is released and the turn moves on.
      if (timeout_hit) begin
        lock   <= 1'b0;
        rr_ptr <= rr_add(owner, PW'(1));
        GRANT  <= '0;
      end

      // A locked owner keeps both its grant and the pointer between frames.
      if (done && !lock) begin
        rr_ptr <= rr_add(owner, PW'(1));
        GRANT  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int BT    = 4;
  localparam int FRAME = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NR-1:0]    REQ_VALID;
  logic [NR*DW-1:0] REQ_DATA;
  logic [NR-1:0]    REQ_LAST;
  logic [NR-1:0]    REQ_READY;
  logic [NR-1:0]    GRANT;
  logic [DW-1:0]    TX_P_DATA;
  logic             TX_DATA_VALID;
  logic             TX_BUSY;
  logic             TIMEOUT_ERR;

  uart_tx_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .REQ_READY(REQ_READY), .GRANT(GRANT),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID),
    .TX_BUSY(TX_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // Per-requester source queues of {last, data}; expected frame order.
  logic [8:0] src_q [NR][$];
  logic [7:0] exp_q [$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   busy_en = 1'b1;
  int   bcnt = 0;
  bit   chk_gap = 1'b0;
  bit   fall_seen = 1'b0;
  int   fall_cyc = 0;
  int   last_dv_cyc = 0;
  int   to_cyc = 0;
  int   to_pulses = 0;
  int   rdy_cnt = 0;
  logic [NR-1:0] grant_at_dv = '0;
  logic [NR-1:0] grant_at_to = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Requester drivers plus a UART_Tx busy model: busy rises the cycle after
  // DATA_Valid and stays high for FRAME cycles.
  initial begin
    logic [NR-1:0] acc;
    logic          dv_s;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    TX_BUSY   = 1'b0;
    forever begin
      @(negedge CLK);
      acc  = REQ_VALID & REQ_READY & {NR{~RST}};
      dv_s = TX_DATA_VALID;
      @(posedge CLK);
      #1;
      if (dv_s && busy_en) bcnt = FRAME;
      else if (bcnt > 0) bcnt--;
      if (!busy_en) bcnt = 0;
      TX_BUSY = (bcnt != 0);
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        REQ_VALID[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          REQ_LAST[i]          = src_q[i][0][8];
          REQ_DATA[i*DW +: DW] = src_q[i][0][7:0];
        end else begin
          REQ_LAST[i]          = 1'b0;
          REQ_DATA[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic busy_prev;
    busy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (busy_prev && !TX_BUSY) begin
        fall_cyc  = cyc;
        fall_seen = 1'b1;
      end
      busy_prev = TX_BUSY;
      if (!RST && (REQ_VALID & REQ_READY) != '0) rdy_cnt++;
      if (REQ_READY != '0) chk("ready_onehot", $countones(REQ_READY), 1);
      if (TX_DATA_VALID) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: actual %0h required none", TX_P_DATA);
        end else begin
          chk("frame_data", TX_P_DATA, exp_q.pop_front());
        end
        if (chk_gap && fall_seen) chk("busy_low_to_valid_gap", cyc - fall_cyc, 2);
        chk("valid_timeout_overlap", TIMEOUT_ERR, 0);
        fall_seen   = 1'b0;
        last_dv_cyc = cyc;
        grant_at_dv = GRANT;
      end
      if (TIMEOUT_ERR) begin
        to_pulses++;
        to_cyc      = cyc;
        grant_at_to = GRANT;
      end
    end
  end

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
    repeat (FRAME + 4) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, GRANT, 0);
    chk({tag, "_dv"}, TX_DATA_VALID, 0);
    chk({tag, "_timeout"}, TIMEOUT_ERR, 0);
    chk({tag, "_pdata"}, TX_P_DATA, 0);
    chk({tag, "_ready"}, REQ_READY, 0);
  endtask

  initial begin
    int n;
    int r0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single byte from req0.
    src_q[0].push_back({1'b1, 8'h55});
    exp_q.push_back(8'h55);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (REQ_READY == '0 && n < 10);
    chk("single_ready", REQ_READY, 4'b0001);
    @(negedge CLK);
    chk("single_dv", TX_DATA_VALID, 1);
    chk("single_pdata", TX_P_DATA, 8'h55);
    chk("single_grant_issue", GRANT, 4'b0001);
    repeat (2) @(negedge CLK);
    chk("single_grant_busy", GRANT, 4'b0001);
    wait_drain("single", 50);
    chk("single_grant_after", GRANT, 0);

    // Frame lock: rr_ptr is now 1, so req1 wins and holds the grant.
    @(negedge CLK);
    src_q[1].push_back({1'b0, 8'h11});
    src_q[1].push_back({1'b1, 8'h12});
    src_q[0].push_back({1'b1, 8'hB0});
    src_q[2].push_back({1'b1, 8'hB2});
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hB0);
    wait_drain("lock", 200);

    // Round robin with all four continuously valid.
    do_reset();
    @(negedge CLK);
    chk_gap   = 1'b1;
    fall_seen = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 0; r < NR; r++) begin
        src_q[r].push_back({1'b1, 8'hA0 + 8'(r)});
        exp_q.push_back(8'hA0 + 8'(r));
      end
    end
    wait_drain("rr", 300);
    chk_gap = 1'b0;

    // Busy timeout on req3.
    do_reset();
    @(negedge CLK);
    busy_en   = 1'b0;
    to_pulses = 0;
    src_q[3].push_back({1'b1, 8'hFF});
    exp_q.push_back(8'hFF);
    n = 0;
    while (to_pulses == 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_seen", to_pulses, 1);
    chk("timeout_latency", to_cyc - last_dv_cyc, BT + 1);
    chk("timeout_grant", grant_at_to, 0);
    repeat (5) @(negedge CLK);
    chk("timeout_single_pulse", to_pulses, 1);
    busy_en = 1'b1;
    // rr_ptr must have advanced past req3 to 0.
    src_q[3].push_back({1'b1, 8'hE3});
    src_q[0].push_back({1'b1, 8'hE0});
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE3);
    wait_drain("after_timeout", 100);

    // Reset in WAIT_DONE of a locked message.
    @(negedge CLK);
    src_q[1].push_back({1'b0, 8'h31});
    src_q[1].push_back({1'b1, 8'h32});
    exp_q.push_back(8'h31);
    n = 0;
    while (!TX_BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("midreset_busy_seen", TX_BUSY, 1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    @(negedge CLK);
    chk_reset_outputs("midreset");
    RST = 1'b0;
    n = 0;
    while (TX_BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    src_q[2].push_back({1'b1, 8'h42});
    exp_q.push_back(8'h42);
    wait_drain("after_reset", 100);
    chk("after_reset_grant", grant_at_dv, 4'b0100);

    // Back-to-back stream from req0.
    @(negedge CLK);
    chk_gap   = 1'b1;
    fall_seen = 1'b0;
    r0 = rdy_cnt;
    for (int b = 0; b < 8; b++) begin
      src_q[0].push_back({1'b1, 8'hC0 + 8'(b)});
      exp_q.push_back(8'hC0 + 8'(b));
    end
    wait_drain("stream", 300);
    chk("stream_ready_count", rdy_cnt - r0, 8);
    chk_gap = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
